// File: rtl/forward_select_unit_pkg.sv
// Shared pipeline-control types and constants for the EX-stage forwarding logic.
package cpu_pipe_pkg;

   localparam int REG_AW = 5;
   localparam int SEL_W  = 2;

   localparam logic [SEL_W-1:0] FWD_RF    = 2'b00;
   localparam logic [SEL_W-1:0] FWD_EXMEM = 2'b01;
   localparam logic [SEL_W-1:0] FWD_MEMWB = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } stage_ctl_t;

   // A stage can supply src only if it will write a real (non-zero) register.
   function automatic logic fwd_hit(input stage_ctl_t s, input logic [REG_AW-1:0] src);
      return s.valid & s.regwrite & (s.rd != '0) & (s.rd == src);
   endfunction

endpackage

// File: rtl/forward_select_unit_if.sv
// ID-stage request and EX-mux select bundle between the decode stage and the forwarding unit.
interface forward_select_unit_if;
   import cpu_pipe_pkg::*;

   // id_valid_i qualifies every id_* field for the current cycle; there is no ready,
   // the unit answers backpressure through stall_o in the same cycle.
   logic              id_valid_i;
   logic [REG_AW-1:0] id_rs_i;
   logic [REG_AW-1:0] id_rt_i;
   logic [REG_AW-1:0] id_rd_i;
   logic              id_regwrite_i;
   logic              id_memread_i;
   logic              flush_i;
   logic [SEL_W-1:0]  fwd_a_sel_o;
   logic [SEL_W-1:0]  fwd_b_sel_o;
   logic              stall_o;
   logic [15:0]       stall_cnt_o;

   modport master (
      output id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
      input  fwd_a_sel_o, fwd_b_sel_o, stall_o, stall_cnt_o
   );

   modport slave (
      input  id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
      output fwd_a_sel_o, fwd_b_sel_o, stall_o, stall_cnt_o
   );

endinterface

// File: rtl/forward_select_unit_fwd_compare.sv
// Picks the operand source for one EX mux; the younger EX/MEM result beats MEM/WB.
module fwd_compare
   import cpu_pipe_pkg::*;
(
   input  logic              src_valid,
   input  logic [REG_AW-1:0] src,
   input  stage_ctl_t        exmem,
   input  stage_ctl_t        memwb,
   output logic [SEL_W-1:0]  sel
);

   logic unused_memread;
   assign unused_memread = exmem.memread ^ memwb.memread;

   always_comb begin
      sel = FWD_RF;
      if (src_valid) begin
         if (fwd_hit(exmem, src)) begin
            sel = FWD_EXMEM;
         end else if (fwd_hit(memwb, src)) begin
            sel = FWD_MEMWB;
         end
      end
   end

endmodule

// File: rtl/forward_select_unit.sv
// Forwarding-select and load-use stall unit tracking ID/EX, EX/MEM and MEM/WB control.
// Optional stall-cycle counter enabled by defining STALL_CNT_EN.
module forward_select_unit
   import cpu_pipe_pkg::*;
(
   input logic                  clk_i,
   input logic                  rst_i,
   forward_select_unit_if.slave bus
);

   stage_ctl_t        idex_q;
   stage_ctl_t        exmem_q;
   stage_ctl_t        memwb_q;
   logic [REG_AW-1:0] idex_rs_q;
   logic [REG_AW-1:0] idex_rt_q;
   logic              stall;
   logic              bubble;

   // A load in EX whose result the ID instruction needs cannot be forwarded in time.
   assign stall = idex_q.valid & idex_q.memread & (idex_q.rd != '0) & bus.id_valid_i &
                  ((idex_q.rd == bus.id_rs_i) | (idex_q.rd == bus.id_rt_i));

   assign bubble = stall | bus.flush_i | ~bus.id_valid_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idex_q    <= '0;
         exmem_q   <= '0;
         memwb_q   <= '0;
         idex_rs_q <= '0;
         idex_rt_q <= '0;
      end else begin
         exmem_q <= idex_q;
         memwb_q <= exmem_q;
         if (bubble) begin
            idex_q    <= '0;
            idex_rs_q <= '0;
            idex_rt_q <= '0;
         end else begin
            idex_q.valid    <= 1'b1;
            idex_q.rd       <= bus.id_rd_i;
            idex_q.regwrite <= bus.id_regwrite_i;
            idex_q.memread  <= bus.id_memread_i;
            idex_rs_q       <= bus.id_rs_i;
            idex_rt_q       <= bus.id_rt_i;
         end
      end
   end

   fwd_compare u_fwd_a (
      .src_valid (idex_q.valid),
      .src       (idex_rs_q),
      .exmem     (exmem_q),
      .memwb     (memwb_q),
      .sel       (bus.fwd_a_sel_o)
   );

   fwd_compare u_fwd_b (
      .src_valid (idex_q.valid),
      .src       (idex_rt_q),
      .exmem     (exmem_q),
      .memwb     (memwb_q),
      .sel       (bus.fwd_b_sel_o)
   );

   assign bus.stall_o = stall;

`ifdef STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign bus.stall_cnt_o = stall_cnt_q;
`else
   assign bus.stall_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_forward_select_unit.sv
// Bench for forward_select_unit: directed vector table, reset corner cases and a random stream.
module tb_forward_select_unit;
   import cpu_pipe_pkg::*;

   typedef struct {
      logic              v;
      logic [REG_AW-1:0] rs, rt, rd;
      logic              rw, mr, fl;
      logic [SEL_W-1:0]  ea, eb;
      logic              es;
   } vec_t;

`ifdef STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   localparam int NVEC = 28;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   forward_select_unit_if bus ();
   forward_select_unit dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

   logic [3:0]  exp_q[$];
   int          compared = 0;
   int          mismatched = 0;
   logic [15:0] exp_cnt = '0;
   stage_ctl_t  m_idex = '0;
   stage_ctl_t  m_exmem = '0;
   vec_t        tbl [NVEC];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int v, input int rs, input int rt, input int rd,
                        input int rw, input int mr, input int fl);
      bus.id_valid_i    = 1'(v);
      bus.id_rs_i       = REG_AW'(rs);
      bus.id_rt_i       = REG_AW'(rt);
      bus.id_rd_i       = REG_AW'(rd);
      bus.id_regwrite_i = 1'(rw);
      bus.id_memread_i  = 1'(mr);
      bus.flush_i       = 1'(fl);
   endtask

   // Inputs already driven: queue this instruction's EX selects, check the previous one's.
   task automatic cycle(input logic [SEL_W-1:0] ea, input logic [SEL_W-1:0] eb, input logic es);
      logic [3:0] e;
      exp_q.push_back({ea, eb});
      @(negedge clk_i);
      check("stall", 16'(bus.stall_o), 16'(es));
      check("stall_cnt", bus.stall_cnt_o, CNT_EN ? exp_cnt : 16'h0);
      if (exp_q.size() > 1) begin
         e = exp_q.pop_front();
         check("fwd_a", 16'(bus.fwd_a_sel_o), 16'(e[3:2]));
         check("fwd_b", 16'(bus.fwd_b_sel_o), 16'(e[1:0]));
      end
      @(posedge clk_i);
      if (es && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_fwd_a", 16'(bus.fwd_a_sel_o), 16'h0);
      check("rst_fwd_b", 16'(bus.fwd_b_sel_o), 16'h0);
      check("rst_stall", 16'(bus.stall_o), 16'h0);
      check("rst_cnt", bus.stall_cnt_o, 16'h0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      exp_q.delete();
      exp_cnt = '0;
      m_idex  = '0;
      m_exmem = '0;
   endtask

   function automatic vec_t mk(input int v, input int rs, input int rt, input int rd,
                               input int rw, input int mr, input int fl,
                               input int ea, input int eb, input int es);
      vec_t r;
      r.v  = 1'(v);  r.rs = REG_AW'(rs); r.rt = REG_AW'(rt); r.rd = REG_AW'(rd);
      r.rw = 1'(rw); r.mr = 1'(mr);      r.fl = 1'(fl);
      r.ea = SEL_W'(ea); r.eb = SEL_W'(eb); r.es = 1'(es);
      return r;
   endfunction

   function automatic logic [SEL_W-1:0] pred(input logic [REG_AW-1:0] src, input logic live,
                                             input stage_ctl_t near, input stage_ctl_t far);
      if (!live) return 2'b00;
      if (near.regwrite && near.rd != '0 && near.rd == src) return 2'b01;
      if (far.regwrite && far.rd != '0 && far.rd == src) return 2'b10;
      return 2'b00;
   endfunction

   initial begin
      logic [3:0] e;
      //            v  rs  rt  rd rw mr fl  ea eb es
      tbl[0]  = mk(1,  5,  6,  1, 1, 0, 0, 0, 0, 0); // add r1
      tbl[1]  = mk(1,  1,  8,  7, 1, 0, 0, 1, 0, 0); // back-to-back use of r1
      tbl[2]  = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(1,  5,  6,  2, 1, 0, 0, 0, 0, 0); // add r2
      tbl[4]  = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
      tbl[5]  = mk(1, 12,  2, 11, 1, 0, 0, 0, 2, 0); // distance two on rt
      tbl[6]  = mk(1,  5,  6,  3, 1, 0, 0, 0, 0, 0); // add r3
      tbl[7]  = mk(1,  5,  6,  3, 1, 0, 0, 0, 0, 0); // add r3 again
      tbl[8]  = mk(1,  3,  3, 13, 1, 0, 0, 1, 1, 0); // EX/MEM wins
      tbl[9]  = mk(1, 14,  4,  4, 1, 1, 0, 0, 0, 0); // lw r4
      tbl[10] = mk(1,  4, 16, 15, 1, 0, 0, 0, 0, 1); // load-use stall
      tbl[11] = mk(1,  4, 16, 15, 1, 0, 0, 2, 0, 0); // retry
      tbl[12] = mk(1,  5,  6,  0, 1, 0, 0, 0, 0, 0); // write r0
      tbl[13] = mk(1,  5,  0,  0, 1, 1, 0, 0, 0, 0); // load to r0
      tbl[14] = mk(1,  0,  0, 17, 1, 0, 0, 0, 0, 0); // use r0
      tbl[15] = mk(1,  5, 18, 18, 1, 1, 0, 0, 0, 0); // lw r18
      tbl[16] = mk(1, 18, 18, 19, 1, 0, 1, 0, 0, 1); // stall + flush
      tbl[17] = mk(1, 21, 22, 20, 1, 0, 0, 0, 0, 0); // add r20
      tbl[18] = mk(1, 20, 20, 21, 1, 0, 1, 0, 0, 0); // flush alone
      tbl[19] = mk(1, 24, 20, 23, 1, 0, 0, 0, 2, 0);
      tbl[20] = mk(1, 23, 23, 25, 1, 0, 0, 1, 1, 0);
      tbl[21] = mk(1,  5, 26, 26, 1, 1, 0, 0, 0, 0); // lw r26
      tbl[22] = mk(1, 27, 26, 29, 1, 0, 0, 0, 0, 1); // load-use via rt
      tbl[23] = mk(1, 27, 26, 29, 1, 0, 0, 0, 2, 0);
      tbl[24] = mk(1,  5, 28, 28, 1, 1, 0, 0, 0, 0); // lw r28
      tbl[25] = mk(0, 28, 28,  0, 0, 0, 0, 0, 0, 0); // invalid ID never stalls
      tbl[26] = mk(1, 28,  5, 30, 1, 0, 0, 2, 0, 0);
      tbl[27] = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0);

      do_reset();

      for (int i = 0; i < NVEC; i++) begin
         drive(int'(tbl[i].v), int'(tbl[i].rs), int'(tbl[i].rt), int'(tbl[i].rd),
               int'(tbl[i].rw), int'(tbl[i].mr), int'(tbl[i].fl));
         cycle(tbl[i].ea, tbl[i].eb, tbl[i].es);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle(2'b00, 2'b00, 1'b0);

      // Reset while an EX/MEM hazard and a load-use stall are both live.
      drive(1, 5, 6, 1, 1, 0, 0);
      cycle(2'b00, 2'b00, 1'b0);
      drive(1, 1, 7, 2, 1, 1, 0);
      cycle(2'b01, 2'b00, 1'b0);
      drive(1, 2, 9, 3, 1, 0, 0);
      @(negedge clk_i);
      e = exp_q.pop_front();
      check("mid_fwd_a", 16'(bus.fwd_a_sel_o), 16'(e[3:2]));
      check("mid_stall", 16'(bus.stall_o), 16'h1);
      #2 rst_i = 1'b1;
      #1;
      check("async_fwd_a", 16'(bus.fwd_a_sel_o), 16'h0);
      check("async_fwd_b", 16'(bus.fwd_b_sel_o), 16'h0);
      check("async_stall", 16'(bus.stall_o), 16'h0);
      check("async_cnt", bus.stall_cnt_o, 16'h0);
      exp_q.delete();
      exp_cnt = '0;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      drive(1, 1, 2, 3, 1, 0, 0);
      cycle(2'b00, 2'b00, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle(2'b00, 2'b00, 1'b0);

      // Random stream over a few registers so hazards are frequent.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic v, rw, mr, fl, st, live;
         logic [REG_AW-1:0] rs, rt, rd;
         v  = ($urandom_range(0, 3) != 0) && (i != 399);
         rs = REG_AW'($urandom_range(0, 3));
         rt = REG_AW'($urandom_range(0, 3));
         rd = REG_AW'($urandom_range(0, 3));
         rw = ($urandom_range(0, 3) != 0);
         mr = ($urandom_range(0, 2) == 0);
         fl = ($urandom_range(0, 7) == 0);
         drive(int'(v), int'(rs), int'(rt), int'(rd), int'(rw), int'(mr), int'(fl));
         st = m_idex.valid & m_idex.memread & (m_idex.rd != '0) & v &
              ((m_idex.rd == rs) | (m_idex.rd == rt));
         live = v & ~st & ~fl;
         cycle(pred(rs, live, m_idex, m_exmem), pred(rt, live, m_idex, m_exmem), st);
         m_exmem = m_idex;
         if (live) begin
            m_idex.valid    = 1'b1;
            m_idex.rd       = rd;
            m_idex.regwrite = rw;
            m_idex.memread  = mr;
         end else begin
            m_idex = '0;
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle(2'b00, 2'b00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
